// File: rtl/vga_pattern_ctrl.sv
// vga_pattern_ctrl
//   VGA timing generator with a built-in test-pattern engine, single clock domain.
//   The pixel rate is a clock enable (pix_ce) from an internal divider, not a derived clock.
//   Registered outputs show the pixel at (h_cnt, v_cnt) one pix_ce after the counters point at it.
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   mode          pattern select: 0 bars, 1 grid, 2 gradient, 3 external
//   ext_data      external pixel for (pix_x, pix_y), valid while pix_req is high
//   pix_req       combinational: pix_ce while the counters are in the active area
//   pix_x, pix_y  combinational: current h/v counters
//   pix_ce        pixel clock enable, one clk wide
//   vga_hs/vs/de  registered sync and data enable
//   vga_rgb       registered {R,G,B}
//   frame_start   one-clk pulse alongside the first output of pixel (0,0)
//   frame_cnt     completed frames, wrapping
module vga_pattern_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [23:0]   ext_data,
    output logic          pix_req,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          pix_ce,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_de,
    output logic [23:0]   vga_rgb,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [1:0]    mode_q;
    logic          h_end;
    logic          v_end;
    logic          h_act;
    logic          v_act;
    logic          hs_on;
    logic          vs_on;
    logic          frame_first;
    logic [1:0]    mode_eff;
    logic [3:0]    bar_idx;
    logic [23:0]   pattern;
    logic [23:0]   rgb_next;

    // Pixel clock-enable divider; CLK_DIV == 1 keeps pix_ce permanently high.
    if (CLK_DIV > 1) begin : g_div
        localparam int unsigned DW = $clog2(CLK_DIV);
        logic [DW-1:0] div_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_cnt <= '0;
            end else if (div_cnt == DW'(CLK_DIV - 1)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end

        assign pix_ce = (div_cnt == DW'(CLK_DIV - 1));
    end else begin : g_nodiv
        assign pix_ce = 1'b1;
    end

    assign h_end       = (h_cnt == CW'(H_TOTAL - 1));
    assign v_end       = (v_cnt == CW'(V_TOTAL - 1));
    assign h_act       = (h_cnt < CW'(H_ACTIVE));
    assign v_act       = (v_cnt < CW'(V_ACTIVE));
    assign hs_on       = (h_cnt >= CW'(HS_START)) && (h_cnt < CW'(HS_END));
    assign vs_on       = (v_cnt >= CW'(VS_START)) && (v_cnt < CW'(VS_END));
    assign frame_first = (h_cnt == '0) && (v_cnt == '0);

    assign pix_req = pix_ce && h_act && v_act;
    assign pix_x   = h_cnt;
    assign pix_y   = v_cnt;

    // Pixel (0,0) already uses the freshly sampled mode so a new frame is uniform.
    assign mode_eff = frame_first ? mode : mode_q;

    // Raster counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Bar index by threshold compare; index 8 is the area past the last full bar.
    always_comb begin
        bar_idx = 4'd0;
        for (int unsigned i = 1; i <= 8; i++) begin
            if (h_cnt >= CW'(i * BAR_W)) begin
                bar_idx = 4'(i);
            end
        end
    end

    // Pattern generator for the current counters.
    always_comb begin
        pattern = 24'h000000;
        case (mode_eff)
            2'd0: begin
                case (bar_idx)
                    4'd0:    pattern = 24'hFFFFFF;
                    4'd1:    pattern = 24'hFFFF00;
                    4'd2:    pattern = 24'h00FFFF;
                    4'd3:    pattern = 24'h00FF00;
                    4'd4:    pattern = 24'hFF00FF;
                    4'd5:    pattern = 24'hFF0000;
                    4'd6:    pattern = 24'h0000FF;
                    default: pattern = 24'h000000;
                endcase
            end
            2'd1: begin
                if ((h_cnt[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0)) begin
                    pattern = 24'hFFFFFF;
                end
            end
            2'd2:    pattern = {h_cnt[7:0], v_cnt[7:0], frame_cnt[7:0]};
            default: pattern = ext_data;
        endcase
        rgb_next = (h_act && v_act) ? pattern : 24'h000000;
    end

    // Output pipeline stage, mode latch and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hs    <= ~HS_POL;
            vga_vs    <= ~VS_POL;
            vga_de    <= 1'b0;
            vga_rgb   <= 24'h000000;
            mode_q    <= 2'd0;
            frame_cnt <= 16'd0;
        end else if (pix_ce) begin
            vga_hs  <= hs_on ? HS_POL : ~HS_POL;
            vga_vs  <= vs_on ? VS_POL : ~VS_POL;
            vga_de  <= h_act && v_act;
            vga_rgb <= rgb_next;
            if (frame_first) begin
                mode_q <= mode;
            end
            if (h_end && v_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Ungated by pix_ce so the pulse lasts exactly one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && frame_first;
        end
    end

endmodule
